// File: rtl/loop_uhat_mul_arbiter_pkg.sv
// Shared constants and tag layout for the loop_uhat shared-multiplier arbiter.
package loop_uhat_mul_pkg;

    localparam int A_WIDTH     = 49;
    localparam int B_WIDTH     = 44;
    localparam int P_WIDTH     = 93;
    localparam int MUL_LATENCY = 4;

    // Widest tag id needed for the largest supported requester count (8).
    localparam int MAX_ID_W    = 3;

    // Tag carried alongside the operands through the multiplier pipeline.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    // Tag width for a given requester count: max(1, clog2(n)).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/loop_uhat_mul_arbiter_if.sv
// Request/response bundle between the requesters/consumer and the arbiter.
interface loop_uhat_mul_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int A_WIDTH     = loop_uhat_mul_pkg::A_WIDTH,
    parameter int B_WIDTH     = loop_uhat_mul_pkg::B_WIDTH,
    parameter int P_WIDTH     = loop_uhat_mul_pkg::P_WIDTH,
    parameter int MUL_LATENCY = loop_uhat_mul_pkg::MUL_LATENCY
) ();
    localparam int ID_W  = loop_uhat_mul_pkg::id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       resp_valid;
    logic [ID_W-1:0]            resp_id;
    logic [P_WIDTH-1:0]         resp_data;
    logic                       resp_ready;
    logic [CNT_W-1:0]           inflight;
    logic                       busy;

    // Requesters plus response consumer.
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, inflight, busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, inflight, busy
    );

endinterface

// File: rtl/loop_uhat_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping. gnt is one-hot (or zero when disabled / nothing requested).
module loop_uhat_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = loop_uhat_mul_pkg::id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    // Rotating priority search starting at the pointer.
    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt_idx  = ID_W'(idx);
                gnt[idx] = en;
            end
        end
    end

endmodule

// File: rtl/loop_uhat_sparse_mul_49ns_44ns_93_5_1.sv
// Unsigned pipelined multiplier core: input registers, then a product
// register chain. dout follows din by NUM_STAGE-1 ce-enabled edges.
// Data registers carry no reset; validity is tracked outside the core.
module loop_uhat_sparse_mul_49ns_44ns_93_5_1 #(
    parameter int NUM_STAGE  = 5,
    parameter int din0_WIDTH = 49,
    parameter int din1_WIDTH = 44,
    parameter int dout_WIDTH = 93
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);
    localparam int DEPTH = NUM_STAGE - 2;

    logic [din0_WIDTH-1:0] a_reg;
    logic [din1_WIDTH-1:0] b_reg;
    logic [dout_WIDTH-1:0] buff [DEPTH];

    // Operand capture, multiply, then shift the product down the chain.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_reg   <= din0;
            b_reg   <= din1;
            buff[0] <= dout_WIDTH'(a_reg) * dout_WIDTH'(b_reg);
            for (int i = 1; i < DEPTH; i++) begin
                buff[i] <= buff[i-1];
            end
        end
    end

    assign dout = buff[DEPTH-1];

endmodule

// File: rtl/loop_uhat_mul_arbiter.sv
// Shares one pipelined 49x44 multiplier among NUM_REQ requesters. A tag
// {valid,id} travels in lock-step with the core; response backpressure
// freezes core and tags together via ce, so nothing is ever dropped.
module loop_uhat_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int A_WIDTH     = loop_uhat_mul_pkg::A_WIDTH,
    parameter int B_WIDTH     = loop_uhat_mul_pkg::B_WIDTH,
    parameter int P_WIDTH     = loop_uhat_mul_pkg::P_WIDTH,
    parameter int MUL_LATENCY = loop_uhat_mul_pkg::MUL_LATENCY
) (
    input  logic                   clk,
    input  logic                   reset,
    loop_uhat_mul_arbiter_if.slave bus
);
    import loop_uhat_mul_pkg::*;

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);
    localparam int TAIL  = MUL_LATENCY - 1;

    tag_t [MUL_LATENCY-1:0] pipe;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        gnt_idx;
    logic [NUM_REQ-1:0]     gnt;
    logic [A_WIDTH-1:0]     din_a;
    logic [B_WIDTH-1:0]     din_b;
    logic [P_WIDTH-1:0]     dout;
    logic [CNT_W-1:0]       cnt;
    logic                   stall;
    logic                   ce;
    logic                   accept;
    logic                   resp_hs;

    // A valid result the consumer refuses freezes the whole pipeline.
    assign stall   = pipe[TAIL].valid & ~bus.resp_ready;
    assign ce      = ~stall;
    assign accept  = |gnt;
    assign resp_hs = bus.resp_valid & bus.resp_ready;

    loop_uhat_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .en      (ce & ~reset),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = gnt;

    // Operand mux from the granted slice; zeros when nothing is granted.
    always_comb begin
        din_a = '0;
        din_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                din_a = bus.req_a[i*A_WIDTH +: A_WIDTH];
                din_b = bus.req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    loop_uhat_sparse_mul_49ns_44ns_93_5_1 #(
        .NUM_STAGE  (MUL_LATENCY + 1),
        .din0_WIDTH (A_WIDTH),
        .din1_WIDTH (B_WIDTH),
        .dout_WIDTH (P_WIDTH)
    ) u_mul (
        .clk  (clk),
        .ce   (ce),
        .din0 (din_a),
        .din1 (din_b),
        .dout (dout)
    );

    // Tag shift register, clocked by the same ce as the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe <= '0;
        end else if (ce) begin
            pipe[0].valid <= accept;
            pipe[0].id    <= MAX_ID_W'(gnt_idx);
            for (int i = 1; i < MUL_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Round-robin pointer moves just past the winner on every accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // Occupancy: accepts in, response handshakes out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            unique case ({accept, resp_hs})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.resp_valid = pipe[TAIL].valid;
    assign bus.resp_data  = dout;
    assign bus.inflight   = cnt;
    assign bus.busy       = |cnt;

    // Tag ids are stored at the widest size; only the low ID_W bits matter.
    if (ID_W < MAX_ID_W) begin : g_id_narrow
        logic [MAX_ID_W-ID_W-1:0] id_hi_unused;
        assign {id_hi_unused, bus.resp_id} = pipe[TAIL].id;
    end else begin : g_id_full
        assign bus.resp_id = pipe[TAIL].id;
    end

endmodule

// File: tb/tb_loop_uhat_mul_arbiter.sv
// Directed bench for loop_uhat_mul_arbiter with a queue-based scoreboard.
module tb_loop_uhat_mul_arbiter;
    import loop_uhat_mul_pkg::*;

    localparam int N = 4;

    typedef struct {
        int                 id;
        logic [P_WIDTH-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] rv = '0;
    logic         rr = 1'b1;

    logic [A_WIDTH-1:0] op_a  [N];
    logic [B_WIDTH-1:0] op_b  [N];
    logic [P_WIDTH-1:0] exp_p [N];

    exp_t exp_q[$];
    int   grant_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_resp   = 0;
    int   base;

    bit                 hold = 1'b0;
    logic [1:0]         hold_id;
    logic [P_WIDTH-1:0] hold_data;

    loop_uhat_mul_arbiter_if #(.NUM_REQ(N)) bus ();

    assign bus.req_valid  = rv;
    assign bus.resp_ready = rr;
    for (genvar i = 0; i < N; i++) begin : g_pack
        assign bus.req_a[i*A_WIDTH +: A_WIDTH] = op_a[i];
        assign bus.req_b[i*B_WIDTH +: B_WIDTH] = op_b[i];
    end

    loop_uhat_mul_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    // Present a request, hold it until accepted (bounded), then drop it.
    task automatic issue(input int id, input logic [A_WIDTH-1:0] a,
                         input logic [B_WIDTH-1:0] b, input logic [P_WIDTH-1:0] p);
        bit got;
        op_a[id] = a; op_b[id] = b; exp_p[id] = p;
        rv[id] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready[id]) got = 1'b1;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: requester %0d actual not accepted, required accept within 64 cycles", id);
        end
        @(posedge clk); #1;
        rv[id] = 1'b0;
    endtask

    // Monitor: hold stability, response scoreboard, accept logging.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", bus.resp_valid, 1);
                chk("hold_id", bus.resp_id, hold_id);
                chk("hold_data", bus.resp_data, hold_data);
            end
            hold      = bus.resp_valid & ~rr;
            hold_id   = bus.resp_id;
            hold_data = bus.resp_data;
            if (bus.resp_valid && rr) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL spurious_resp: actual id %0d data %0h, required no response",
                             bus.resp_id, bus.resp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_id", bus.resp_id, e.id);
                    chk("resp_data", bus.resp_data, e.data);
                    n_resp++;
                end
            end
            chk("ready_onehot0", $onehot0(bus.req_ready), 1);
            for (int i = 0; i < N; i++) begin
                if (rv[i] && bus.req_ready[i]) begin
                    exp_q.push_back('{id: i, data: exp_p[i]});
                    grant_log.push_back(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; exp_p[i] = '0;
        end
        rv = '1;
        #12;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_inflight", bus.inflight, 0);
        chk("rst_busy", bus.busy, 0);
        rv = '0;
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // Single request: requester 2, 3*5.
        op_a[2] = 3; op_b[2] = 5; exp_p[2] = 15;
        rv[2] = 1'b1;
        @(negedge clk);
        chk("t1_ready_same_cycle", bus.req_ready, 4'b0100);
        @(posedge clk); #1;
        rv[2] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t1_resp_early", bus.resp_valid, 0);
        end
        @(negedge clk);
        chk("t1_resp_at_4", bus.resp_valid, 1);
        chk("t1_resp_id", bus.resp_id, 2);
        chk("t1_resp_data", bus.resp_data, 15);
        @(negedge clk);
        chk("t1_resp_after", bus.resp_valid, 0);
        @(posedge clk); #1;

        // Maximum operands on requester 3.
        issue(3, 49'h1_FFFF_FFFF_FFFF, 44'hFFF_FFFF_FFFF, 93'h1FFFFFFFFFFDF00000000001);
        repeat (6) @(posedge clk);
        #1;

        // Round-robin fairness: all requesters held for 8 cycles.
        for (int i = 0; i < N; i++) begin
            op_a[i] = A_WIDTH'(i + 1); op_b[i] = 10;
        end
        exp_p[0] = 10; exp_p[1] = 20; exp_p[2] = 30; exp_p[3] = 40;
        grant_log.delete();
        rv = '1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c >= 3) chk("t3_inflight_full", bus.inflight, 4);
        end
        rv = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("t3_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < grant_log.size()) chk("t3_grant_order", grant_log[k], k % 4);
        end

        // Backpressure with a full pipeline; requesters retry during the stall.
        base = n_resp;
        rr = 1'b0;
        fork
            issue(0, 100, 7, 700);
            issue(1, 101, 7, 707);
            issue(2, 102, 7, 714);
            issue(3, 103, 7, 721);
        join
        fork
            begin
                fork
                    issue(0, 100, 7, 700);
                    issue(1, 101, 7, 707);
                    issue(2, 102, 7, 714);
                    issue(3, 103, 7, 721);
                join
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t4_ready_stalled", bus.req_ready, 0);
                    chk("t4_inflight", bus.inflight, 4);
                    chk("t4_busy", bus.busy, 1);
                end
                @(posedge clk); #1;
                rr = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("t4_resp_count", n_resp - base, 8);

        // Asynchronous reset with three requests in flight.
        fork
            issue(0, 11, 13, 143);
            issue(1, 17, 19, 323);
            issue(2, 23, 29, 667);
        join
        chk("t5_pre_inflight", bus.inflight, 3);
        chk("t5_pre_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_resp_valid", bus.resp_valid, 0);
        chk("t5_rst_inflight", bus.inflight, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_req_ready", bus.req_ready, 0);
        @(posedge clk); #3;
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_spurious", bus.resp_valid, 0);
        end
        @(posedge clk); #1;
        grant_log.delete();
        fork
            issue(1, 6, 7, 42);
            issue(3, 8, 9, 72);
        join
        repeat (6) @(posedge clk);
        #1;
        chk("t5_grant_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t5_first_grant", grant_log[0], 1);
            chk("t5_second_grant", grant_log[1], 3);
        end

        // Requester 3 waits through a stall, accepted when ce returns.
        base = n_resp;
        grant_log.delete();
        rr = 1'b0;
        issue(0, 2, 3, 6);
        repeat (3) @(posedge clk);
        #1;
        op_a[3] = 9; op_b[3] = 9; exp_p[3] = 81;
        rv[3] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_accept", bus.req_ready, 0);
            chk("t6_tail_valid", bus.resp_valid, 1);
        end
        @(posedge clk); #1;
        rr = 1'b1;
        @(negedge clk);
        chk("t6_accept_on_release", bus.req_ready, 4'b1000);
        @(posedge clk); #1;
        rv[3] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t6_resp_count", n_resp - base, 2);
        chk("t6_accept_count", grant_log.size(), 2);

        repeat (3) @(posedge clk);
        #1;
        chk("final_drain", exp_q.size(), 0);
        chk("final_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
